// File: rtl/reg_bank_scanner_pkg.sv
// Shared definitions for the reg_bank_scanner slice.
//   rbs_state_e : read-select FSM state codes (ST_MANUAL = 0, ST_SCAN = 1)
//   rbs_clog2   : ceiling log2 for deriving address/counter widths from parameters
package reg_bank_scanner_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } rbs_state_e;

  // Returns ceil(log2(value)); rbs_clog2(1) == 0.
  function automatic int rbs_clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/reg_bank_scanner_if.sv
// Bus bundle for reg_bank_scanner.
//   Parameters: DATA_W (register width), DEPTH (register count); ADDR_W is derived.
//   master modport (driver side) : drives wr_en, wr_addr, wr_data, clr, scan_en, rd_addr;
//                                  receives q_out, cur_addr, scanning, wrap
//   slave modport  (bank side)   : the mirror image
interface reg_bank_scanner_if
  import reg_bank_scanner_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int ADDR_W = rbs_clog2(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr;
  logic              scan_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] q_out;
  logic [ADDR_W-1:0] cur_addr;
  logic              scanning;
  logic              wrap;

  modport master (
    output wr_en, wr_addr, wr_data, clr, scan_en, rd_addr,
    input  q_out, cur_addr, scanning, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr, scan_en, rd_addr,
    output q_out, cur_addr, scanning, wrap
  );

endinterface

// File: rtl/reg_bank_scanner_scan_counter.sv
// Dwell-timed scan address generator.
//   Ports:
//     CLOCK_50  in  clock, all state on posedge
//     RESET     in  asynchronous active-high reset
//     run       in  advance the dwell counter this cycle
//     start     in  restart: scan_addr and dwell count to 0 (takes priority over run)
//     scan_addr out current scan address, 0..DEPTH-1
//     wrap      out registered pulse, high for the cycle after scan_addr wraps DEPTH-1 -> 0
//   Each address is held for DWELL cycles of run.
module reg_bank_scanner_scan_counter
  import reg_bank_scanner_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DWELL  = 50_000_000,
  localparam int ADDR_W = rbs_clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              run,
  input  logic              start,
  output logic [ADDR_W-1:0] scan_addr,
  output logic              wrap
);

  // One extra bit keeps the width non-zero when DWELL == 1.
  localparam int                CNT_W      = rbs_clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

  logic [CNT_W-1:0] dwell_cnt;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      dwell_cnt <= '0;
      scan_addr <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (start) begin
        dwell_cnt <= '0;
        scan_addr <= '0;
      end else if (run) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt <= '0;
          if (scan_addr == ADDR_LAST) begin
            scan_addr <= '0;
            wrap      <= 1'b1;
          end else begin
            scan_addr <= scan_addr + 1'b1;
          end
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_scanner.sv
// DEPTH x DATA_W register bank with one write port and one registered read port.
// The read address is bus.rd_addr in MANUAL mode or a dwell-timed scan address in
// SCAN mode, so every register can be shown in turn on a display bus.
//   Ports:
//     CLOCK_50  in  clock, all state on posedge
//     RESET     in  asynchronous active-high reset
//     bus       reg_bank_scanner_if.slave: write port (wr_en/wr_addr/wr_data), clr,
//               scan_en, rd_addr in; q_out, cur_addr, scanning, wrap out (all registered)
//   Build option: define RBS_WR_BYPASS_EN to forward a same-cycle write (or clear)
//   to q_out; without it q_out always shows pre-edge register contents.
module reg_bank_scanner
  import reg_bank_scanner_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DWELL  = 50_000_000
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  reg_bank_scanner_if.slave   bus
);

  localparam int                ADDR_W  = rbs_clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  rbs_state_e        state;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] rd_data;
  logic              cnt_wrap;
  logic              start;
  logic              run;
  logic              sel_ok;
  logic              wr_ok;

  assign start  = (state == ST_MANUAL) && bus.scan_en;
  assign run    = (state == ST_SCAN) && bus.scan_en;
  assign sel    = (state == ST_SCAN) ? scan_addr : bus.rd_addr;
  assign sel_ok = ({1'b0, sel} < DEPTH_C);
  assign wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C);

  reg_bank_scanner_scan_counter #(
    .DEPTH (DEPTH),
    .DWELL (DWELL)
  ) u_scan_counter (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .run       (run),
    .start     (start),
    .scan_addr (scan_addr),
    .wrap      (cnt_wrap)
  );

  // Register array: clear beats write; out-of-range writes are dropped.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (sel_ok) rd_data = regs[sel];
`ifdef RBS_WR_BYPASS_EN
    if (bus.clr) begin
      rd_data = '0;
    end else if (wr_ok && (bus.wr_addr == sel)) begin
      rd_data = bus.wr_data;
    end
`endif
  end

  // FSM and output registers. wrap is delayed one cycle from the counter so it
  // rises together with cur_addr returning to 0.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state        <= ST_MANUAL;
      bus.scanning <= 1'b0;
      bus.wrap     <= 1'b0;
      bus.q_out    <= '0;
      bus.cur_addr <= '0;
    end else begin
      case (state)
        ST_MANUAL: begin
          if (bus.scan_en) begin
            state        <= ST_SCAN;
            bus.scanning <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (!bus.scan_en) begin
            state        <= ST_MANUAL;
            bus.scanning <= 1'b0;
          end
        end
        default: begin
          state        <= ST_MANUAL;
          bus.scanning <= 1'b0;
        end
      endcase
      bus.wrap     <= cnt_wrap;
      bus.q_out    <= rd_data;
      bus.cur_addr <= sel;
    end
  end

endmodule

// File: tb/tb_reg_bank_scanner.sv
// Directed bench for reg_bank_scanner with DATA_W=8, DEPTH=5, DWELL=4.
// Build with or without RBS_WR_BYPASS_EN; expectations follow the same macro.
module tb_reg_bank_scanner;

`ifdef RBS_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RESET    = 1'b1;

  always #5 CLOCK_50 = ~CLOCK_50;

  reg_bank_scanner_if #(.DATA_W(8), .DEPTH(5)) bus ();

  reg_bank_scanner #(
    .DATA_W (8),
    .DEPTH  (5),
    .DWELL  (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus.slave)
  );

  typedef struct {
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic [2:0] rd_addr;
    logic [7:0] q_nb;   // expected q_out without bypass
    logic [7:0] q_bp;   // expected q_out with bypass
    logic [2:0] cur;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                              input logic c, input logic [2:0] ra,
                              input logic [7:0] qnb, input logic [7:0] qbp,
                              input logic [2:0] cu);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.clr = c; v.rd_addr = ra;
    v.q_nb = qnb; v.q_bp = qbp; v.cur = cu;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    logic [7:0] exp_q;
    int         exp_cur;
    int         wraps;

    vecs[0]  = mk(0, 0, 8'h00, 0, 3, 8'h00, 8'h00, 3);
    vecs[1]  = mk(1, 2, 8'hA5, 0, 3, 8'h00, 8'h00, 3);
    vecs[2]  = mk(0, 0, 8'h00, 0, 2, 8'hA5, 8'hA5, 2);
    vecs[3]  = mk(1, 7, 8'hFF, 0, 2, 8'hA5, 8'hA5, 2);
    vecs[4]  = mk(0, 0, 8'h00, 0, 7, 8'h00, 8'h00, 7);
    vecs[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1);
    vecs[7]  = mk(0, 0, 8'h00, 0, 3, 8'h00, 8'h00, 3);
    vecs[8]  = mk(0, 0, 8'h00, 0, 4, 8'h00, 8'h00, 4);
    vecs[9]  = mk(1, 1, 8'h3C, 0, 1, 8'h00, 8'h3C, 1);
    vecs[10] = mk(0, 0, 8'h00, 0, 1, 8'h3C, 8'h3C, 1);
    vecs[11] = mk(1, 0, 8'h11, 0, 0, 8'h00, 8'h11, 0);
    vecs[12] = mk(1, 0, 8'h77, 1, 0, 8'h11, 8'h00, 0);
    vecs[13] = mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    vecs[14] = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 1);
    vecs[15] = mk(0, 0, 8'h00, 0, 2, 8'h00, 8'h00, 2);

    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.clr = 0; bus.scan_en = 0; bus.rd_addr = 0;

    // Reset state
    step(); step();
    chk("reset_q", bus.q_out, 0);
    chk("reset_cur", bus.cur_addr, 0);
    chk("reset_scanning", bus.scanning, 0);
    chk("reset_wrap", bus.wrap, 0);
    RESET = 1'b0;

    // Manual-mode table: write, out-of-range write/read, read-during-write, clr vs write
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_addr = vecs[i].wr_addr;
      bus.wr_data = vecs[i].wr_data;
      bus.clr     = vecs[i].clr;
      bus.rd_addr = vecs[i].rd_addr;
      step();
      chk($sformatf("vec%0d_q", i), bus.q_out, BYPASS ? vecs[i].q_bp : vecs[i].q_nb);
      chk($sformatf("vec%0d_cur", i), bus.cur_addr, vecs[i].cur);
      chk($sformatf("vec%0d_scanning", i), bus.scanning, 0);
    end
    bus.wr_en = 0; bus.clr = 0;

    // Load 0x10..0x14 and scan
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1; bus.wr_addr = 3'(i); bus.wr_data = 8'(8'h10 + i);
      step();
    end
    bus.wr_en = 0;
    bus.rd_addr = 2;
    bus.scan_en = 1;
    step();
    chk("scan_entry_scanning", bus.scanning, 1);
    chk("scan_entry_cur", bus.cur_addr, 2);
    chk("scan_entry_q", bus.q_out, 8'h12);
    wraps = 0;
    for (int k = 1; k <= 44; k++) begin
      step();
      exp_cur = ((k - 1) / 4) % 5;
      exp_q   = 8'(8'h10 + exp_cur);
      chk($sformatf("scan%0d_cur", k), bus.cur_addr, exp_cur);
      chk($sformatf("scan%0d_q", k), bus.q_out, exp_q);
      chk($sformatf("scan%0d_wrap", k), bus.wrap, (k == 21 || k == 41) ? 1 : 0);
      if (bus.wrap) wraps++;
    end
    chk("scan_wrap_count", wraps, 2);

    // Drop scan at address 3, then re-enter: restart at 0 with a full dwell
    bus.scan_en = 0;
    step(); step();
    chk("exit_scanning", bus.scanning, 0);
    bus.scan_en = 1;
    step();
    for (int k = 1; k <= 13; k++) step();
    chk("mid_cur3", bus.cur_addr, 3);
    chk("mid_q3", bus.q_out, 8'h13);
    bus.scan_en = 0;
    step();
    chk("drop_scanning", bus.scanning, 0);
    chk("drop_cur", bus.cur_addr, 3);
    bus.scan_en = 1;
    step();
    chk("reenter_scanning", bus.scanning, 1);
    chk("reenter_cur", bus.cur_addr, 2);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("reenter%0d_cur", k), bus.cur_addr, 0);
      chk($sformatf("reenter%0d_q", k), bus.q_out, 8'h10);
    end
    step();
    chk("reenter5_cur", bus.cur_addr, 1);
    chk("reenter5_q", bus.q_out, 8'h11);

    // Asynchronous reset mid-scan, away from the clock edge
    #3;
    RESET = 1'b1;
    #1;
    chk("async_q", bus.q_out, 0);
    chk("async_cur", bus.cur_addr, 0);
    chk("async_scanning", bus.scanning, 0);
    chk("async_wrap", bus.wrap, 0);
    step();
    RESET = 1'b0;
    bus.scan_en = 0;
    bus.rd_addr = 3;
    step();
    chk("post_reset_q3", bus.q_out, 0);
    chk("post_reset_cur3", bus.cur_addr, 3);
    bus.rd_addr = 0;
    step();
    chk("post_reset_q0", bus.q_out, 0);
    chk("post_reset_scanning", bus.scanning, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
